// File: rtl/pipeline_types.sv
// Shared types and defaults for the pulse-width timer (WS2812-style line decoding).
// The PWT_SAT_FLAG_EN build uses the capture struct to carry the saturation flag.
package pipeline_types;

  localparam int PWT_DEFAULT_WIDTH       = 10;
  localparam int PWT_WS2812_RESET_THRESH = 400;

  typedef struct packed {
    logic level;
    logic sat;
  } pwt_capture_t;

endpackage

// File: rtl/pwt_channel.sv
// One pulse-width measurement channel: edge detect, saturating counter, capture and reset-gap strobe.
// Optional feature macro: PWT_SAT_FLAG_EN adds o_sat, set when the captured width is full scale.
module pwt_channel
  import pipeline_types::*;
#(
  parameter int WIDTH        = PWT_DEFAULT_WIDTH,
  parameter int RESET_THRESH = PWT_WS2812_RESET_THRESH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_count_enable,
  input  logic             i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_width,
  output logic             o_level,
`ifdef PWT_SAT_FLAG_EN
  output logic             o_reset_det,
  output logic             o_sat
`else
  output logic             o_reset_det
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] THRESH  = WIDTH'(RESET_THRESH);

  logic             data_prev_q, data_prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic             valid_q, valid_d;
  logic             reset_det_q, reset_det_d;
  logic             edge_det;

`ifdef PWT_SAT_FLAG_EN
  pwt_capture_t     cap_q, cap_d;
`else
  logic             level_q, level_d;
`endif

  always_comb begin
    edge_det    = (i_data != data_prev_q);
    data_prev_d = i_data;
    count_d     = count_q;
    if (edge_det)
      count_d = '0;
    else if (i_count_enable && count_q != CNT_MAX)
      count_d = count_q + 1'b1;

    valid_d = edge_det;
    width_d = edge_det ? count_q : width_q;
    // Fires only on the transition into the threshold during a low period; an edge clears the
    // counter so it can never reach the threshold on that same cycle.
    reset_det_d = !data_prev_q && (count_d == THRESH) && (count_q != THRESH);

`ifdef PWT_SAT_FLAG_EN
    cap_d = cap_q;
    if (edge_det) begin
      cap_d.level = data_prev_q;
      cap_d.sat   = (count_q == CNT_MAX);
    end
`else
    level_d = edge_det ? data_prev_q : level_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_prev_q <= 1'b0;
      count_q     <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      reset_det_q <= 1'b0;
`ifdef PWT_SAT_FLAG_EN
      cap_q       <= '0;
`else
      level_q     <= 1'b0;
`endif
    end else begin
      data_prev_q <= data_prev_d;
      count_q     <= count_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      reset_det_q <= reset_det_d;
`ifdef PWT_SAT_FLAG_EN
      cap_q       <= cap_d;
`else
      level_q     <= level_d;
`endif
    end
  end

  assign o_valid     = valid_q;
  assign o_width     = width_q;
  assign o_reset_det = reset_det_q;
`ifdef PWT_SAT_FLAG_EN
  assign o_level     = cap_q.level;
  assign o_sat       = cap_q.sat;
`else
  assign o_level     = level_q;
`endif

endmodule

// File: rtl/pulse_width_timer.sv
// Multi-channel pulse-width timer: NUM_CH independent pwt_channel instances sharing one count strobe.
// Optional feature macro: PWT_SAT_FLAG_EN adds the per-channel o_sat output.
module pulse_width_timer
  import pipeline_types::*;
#(
  parameter int NUM_CH       = 1,
  parameter int WIDTH        = PWT_DEFAULT_WIDTH,
  parameter int RESET_THRESH = PWT_WS2812_RESET_THRESH
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_count_enable,
  input  logic [NUM_CH-1:0]             i_data,
  output logic [NUM_CH-1:0]             o_valid,
  output logic [NUM_CH-1:0][WIDTH-1:0]  o_width,
  output logic [NUM_CH-1:0]             o_level,
`ifdef PWT_SAT_FLAG_EN
  output logic [NUM_CH-1:0]             o_reset_det,
  output logic [NUM_CH-1:0]             o_sat
`else
  output logic [NUM_CH-1:0]             o_reset_det
`endif
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwt_channel #(
      .WIDTH        (WIDTH),
      .RESET_THRESH (RESET_THRESH)
    ) u_channel (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_count_enable (i_count_enable),
      .i_data         (i_data[gi]),
      .o_valid        (o_valid[gi]),
      .o_width        (o_width[gi]),
      .o_level        (o_level[gi]),
`ifdef PWT_SAT_FLAG_EN
      .o_reset_det    (o_reset_det[gi]),
      .o_sat          (o_sat[gi])
`else
      .o_reset_det    (o_reset_det[gi])
`endif
    );
  end

endmodule

// File: tb/tb_pulse_width_timer.sv
// Directed bench for pulse_width_timer (NUM_CH=2, WIDTH=10, RESET_THRESH=400).
// The edge-detect clock clears the counter, so a pulse measuring n counts spans n+1 sampled clocks.
module tb_pulse_width_timer;

  localparam int NUM_CH       = 2;
  localparam int WIDTH        = 10;
  localparam int RESET_THRESH = 400;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         en;
  logic [NUM_CH-1:0]            data;
  logic [NUM_CH-1:0]            o_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] o_width;
  logic [NUM_CH-1:0]            o_level;
  logic [NUM_CH-1:0]            o_reset_det;
`ifdef PWT_SAT_FLAG_EN
  logic [NUM_CH-1:0]            o_sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit div4     = 1'b0;
  int det_cnt [NUM_CH];
  int base0, base1;

  always #5 clk = ~clk;

  pulse_width_timer #(
    .NUM_CH       (NUM_CH),
    .WIDTH        (WIDTH),
    .RESET_THRESH (RESET_THRESH)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_count_enable (en),
    .i_data         (data),
    .o_valid        (o_valid),
    .o_width        (o_width),
    .o_level        (o_level),
`ifdef PWT_SAT_FLAG_EN
    .o_reset_det    (o_reset_det),
    .o_sat          (o_sat)
`else
    .o_reset_det    (o_reset_det)
`endif
  );

  initial for (int c = 0; c < NUM_CH; c++) det_cnt[c] = 0;

  always @(negedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (o_reset_det[c]) det_cnt[c]++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (div4) en = (cyc % 4 == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    data  = '0;
    #1;
    step(2);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_width", 32'(o_width), 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_det",   32'(o_reset_det), 0);
`ifdef PWT_SAT_FLAG_EN
    check("rst_sat",   32'(o_sat), 0);
`endif
    rst_n = 1'b1;

    // High pulse of 35 counts on channel 0, channel 1 idle.
    data[0] = 1'b1;
    step(36);
    data[0] = 1'b0;
    step(1);
    check("p35_valid",  32'(o_valid), 32'h1);
    check("p35_width",  32'(o_width[0]), 35);
    check("p35_level",  32'(o_level[0]), 1);
    check("p35_w1idle", 32'(o_width[1]), 0);
`ifdef PWT_SAT_FLAG_EN
    check("p35_sat",    32'(o_sat[0]), 0);
`endif
    step(1);
    check("p35_onecyc", 32'(o_valid), 0);
    check("p35_hold_w", 32'(o_width[0]), 35);

    // Count strobe dropped mid-pulse: 15 counts, then frozen for 20 clocks.
    data[0] = 1'b1;
    step(16);
    en = 1'b0;
    step(20);
    data[0] = 1'b0;
    step(1);
    check("frz_valid", 32'(o_valid[0]), 1);
    check("frz_width", 32'(o_width[0]), 15);
    en = 1'b1;

    // Count strobe every 4th clock across a 40-clock pulse.
    div4 = 1'b1;
    data[0] = 1'b1;
    step(41);
    data[0] = 1'b0;
    step(1);
    check("div4_width", 32'(o_width[0]), 10);
    div4 = 1'b0;
    en   = 1'b1;

    // Simultaneous falling edges: ch1 after 50 counts, ch0 after 20.
    data[1] = 1'b1;
    step(30);
    data[0] = 1'b1;
    step(21);
    data = 2'b00;
    step(1);
    check("sim_valid",  32'(o_valid), 32'h3);
    check("sim_width0", 32'(o_width[0]), 20);
    check("sim_width1", 32'(o_width[1]), 50);
    check("sim_level",  32'(o_level), 32'h3);

    // Reset mid-pulse at count 100.
    data[0] = 1'b1;
    step(101);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_width", 32'(o_width), 0);
    check("mid_rst_level", 32'(o_level), 0);
    check("mid_rst_det",   32'(o_reset_det), 0);
`ifdef PWT_SAT_FLAG_EN
    check("mid_rst_sat",   32'(o_sat), 0);
`endif
    step(3);
    check("mid_rst_hold", 32'(o_width), 0);
    rst_n = 1'b1;
    step(1);
    check("rel_edge_valid", 32'(o_valid), 32'h1);
    check("rel_edge_width", 32'(o_width[0]), 0);
    check("rel_edge_level", 32'(o_level[0]), 0);
    step(30);
    data[0] = 1'b0;
    step(1);
    check("rel_valid", 32'(o_valid), 32'h1);
    check("rel_width", 32'(o_width[0]), 30);
    check("rel_level", 32'(o_level[0]), 1);

    // Long low on ch1 (reset gap + saturation), long high on ch0 (never a reset gap).
    rst_n = 1'b0;
    data  = 2'b01;
    step(2);
    rst_n = 1'b1;
    base0 = det_cnt[0];
    base1 = det_cnt[1];
    step(1200);
    data[1] = 1'b1;
    step(1);
    check("gap_det1",   32'(det_cnt[1] - base1), 1);
    check("gap_det0",   32'(det_cnt[0] - base0), 0);
    check("gap_valid1", 32'(o_valid[1]), 1);
    check("gap_width1", 32'(o_width[1]), 1023);
    check("gap_level1", 32'(o_level[1]), 0);
`ifdef PWT_SAT_FLAG_EN
    check("gap_sat1",   32'(o_sat[1]), 1);
`endif

    // Rising edge on the cycle the low count would reach the threshold.
    data[1] = 1'b0;
    base1 = det_cnt[1];
    step(400);
    data[1] = 1'b1;
    step(1);
    check("thr399_valid", 32'(o_valid[1]), 1);
    check("thr399_width", 32'(o_width[1]), 399);
    check("thr399_det",   32'(det_cnt[1] - base1), 0);
`ifdef PWT_SAT_FLAG_EN
    check("thr399_sat",   32'(o_sat[1]), 0);
`endif

    // One count longer: the gap strobe fires exactly once.
    data[1] = 1'b0;
    base1 = det_cnt[1];
    step(401);
    data[1] = 1'b1;
    step(1);
    check("thr400_width", 32'(o_width[1]), 400);
    check("thr400_det",   32'(det_cnt[1] - base1), 1);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
